instrumented_adder_sequencer: RTL

Host-side measurement sequencer for the instrumented adder. It accepts a measurement command (operands plus run length) over a valid/ready handshake, then drives the adder's operand and control inputs. It gates the ring/chain counter for an exact number of clocks, waits for the counter to settle, and returns the captured count over a second valid/ready handshake. It replaces manual logic-analyzer poking, sitting between a host-side command source and the `wrapped_instrumented_adder` control/count inputs.

---
 rtl/instrumented_adder_seq_pkg.sv | 21 ++
 rtl/instrumented_adder_seq_timer.sv | 27 ++
 rtl/instrumented_adder_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/instrumented_adder_seq_pkg.sv
// Shared types and constants for the instrumented adder measurement sequencer.
package instrumented_adder_seq_pkg;

  localparam int DATA_W           = 32;
  localparam int CYCLES_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_SETTLE,
    ST_RESULT
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/instrumented_adder_seq_timer.sv
// Loadable down-counter shared by the clear, run and settle intervals.
module instrumented_adder_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/instrumented_adder_sequencer.sv
// Measurement sequencer: accepts a command, gates the adder's counter for an
// exact number of clocks, waits for the count to settle and returns it.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | cmd_ready=1, waiting for a command handshake
// ST_LOAD   | dut_cnt_clear held for CLEAR_CYCLES clocks
// ST_RUN    | dut_run held for exactly cmd_cycles clocks
// ST_SETTLE | run/clear low for SETTLE_CYCLES; count sampled on last clock
// ST_RESULT | res_valid=1 until the result handshake
module instrumented_adder_sequencer
  import instrumented_adder_seq_pkg::*;
#(
  parameter int CYCLES_W      = CYCLES_W_DEFAULT,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic [CYCLES_W-1:0] cmd_cycles,
  output logic [DATA_W-1:0]   dut_a,
  output logic [DATA_W-1:0]   dut_b,
  output logic                dut_cnt_clear,
  output logic                dut_run,
  input  logic [DATA_W-1:0]   dut_count,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_count,
  output logic                res_err
);

  // Timer wide enough for the full run length and both fixed intervals.
  localparam int TW = max3(CYCLES_W, $clog2(CLEAR_CYCLES + 1), $clog2(SETTLE_CYCLES + 1));
  localparam logic [TW-1:0] CLEAR_LOAD  = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  seq_state_e          state, state_next;
  logic [CYCLES_W-1:0] cyc_q;
  logic                accept;
  logic                capture;
  logic                tmr_load;
  logic                tmr_en;
  logic                tmr_zero;
  logic [TW-1:0]       tmr_value;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  instrumented_adder_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .load  (tmr_load),
    .en    (tmr_en),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // Each timed state is entered with (length - 1) loaded, so it lasts
  // exactly 'length' clocks and leaves when the timer reads zero.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_value  = '0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_cycles != '0) begin
            state_next = ST_LOAD;
            tmr_load   = 1'b1;
            tmr_value  = CLEAR_LOAD;
          end else begin
            state_next = ST_RESULT;
          end
        end
      end
      ST_LOAD: begin
        if (tmr_zero) begin
          state_next = ST_RUN;
          tmr_load   = 1'b1;
          tmr_value  = TW'(cyc_q) - TW'(1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (tmr_zero) begin
          state_next = ST_SETTLE;
          tmr_load   = 1'b1;
          tmr_value  = SETTLE_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_next = ST_RESULT;
          capture    = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Control outputs are registered from the next state so they line up
  // exactly with the state they belong to.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      cyc_q         <= '0;
      dut_a         <= '0;
      dut_b         <= '0;
      dut_cnt_clear <= 1'b0;
      dut_run       <= 1'b0;
      res_valid     <= 1'b0;
      res_count     <= '0;
      res_err       <= 1'b0;
    end else begin
      state         <= state_next;
      dut_cnt_clear <= (state_next == ST_LOAD);
      dut_run       <= (state_next == ST_RUN);
      res_valid     <= (state_next == ST_RESULT);
      if (accept) begin
        dut_a   <= cmd_a;
        dut_b   <= cmd_b;
        cyc_q   <= cmd_cycles;
        res_err <= (cmd_cycles == '0);
        if (cmd_cycles == '0) begin
          res_count <= '0;
        end
      end
      if (capture) begin
        res_count <= dut_count;
      end
    end
  end

endmodule
